// File: rtl/mem_responder.sv
// mem_responder: fixed-latency, one-outstanding-request data memory with optional wrapping burst reads
// Ports: clk, rst (async, active-high); enable/wr/burst/addr/data_in request in;
//        ready (idle, accepting), data_valid/data_out/beat read beat out (data_out and beat are 0 when no beat).
module mem_responder #(
  parameter int MEM_WORDS_LOG2 = 10,
  parameter int LATENCY = 4,
  parameter int BURST_LEN = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic wr,
  input  logic burst,
  input  logic [15:0] addr,
  input  logic [15:0] data_in,
  output logic ready,
  output logic data_valid,
  output logic [15:0] data_out,
  output logic [$clog2(BURST_LEN)-1:0] beat
);
  localparam int MW = MEM_WORDS_LOG2;
  localparam int BW = $clog2(BURST_LEN);
  localparam int CW = $clog2(LATENCY + BURST_LEN);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [15:0] mem [0:(1<<MW)-1];
  logic wr_q, burst_q;
  logic [MW-1:0] word_q, rd_idx;
  logic [BW-1:0] offs;
  logic accept;
  logic unused_addr;
  assign unused_addr = ^{addr[0], addr[15:MW+1]};
  assign accept = enable && ready;
  assign ready = state == IDLE;
  assign data_valid = state == RESP;
  // critical-word-first: beat i carries the word at (start + i) mod BURST_LEN within the aligned block
  assign offs = word_q[BW-1:0] + cnt[BW-1:0];
  assign rd_idx = burst_q ? {word_q[MW-1:BW], offs} : word_q;
  assign data_out = data_valid ? mem[rd_idx] : '0;
  assign beat = data_valid ? cnt[BW-1:0] : '0;
  always_comb begin
    state_n = state;
    cnt_n = cnt + 1'b1;
    if (state == IDLE) begin
      cnt_n = '0;
      state_n = enable ? WAIT : IDLE;
    end else if (state == WAIT && cnt == CW'(LATENCY - 1)) begin
      cnt_n = '0;
      state_n = wr_q ? IDLE : RESP;
    end else if (state == RESP && cnt == (burst_q ? CW'(BURST_LEN - 1) : '0)) begin
      cnt_n = '0;
      state_n = IDLE;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      wr_q <= 1'b0;
      burst_q <= 1'b0;
      word_q <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      if (accept) begin
        wr_q <= wr;
        burst_q <= burst && !wr;
        word_q <= addr[MW:1];
      end
    end
  end
  // storage is deliberately not reset; a write commits at its accept edge
  always_ff @(posedge clk) begin
    if (accept && wr && !rst) mem[addr[MW:1]] <= data_in;
  end
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: randomized self-checking bench for mem_responder against a word-array model
module tb_mem_responder;
  localparam int LAT = 4;
  localparam int BL = 4;
  logic clk = 0, rst = 0, enable = 0, wr = 0, burst = 0;
  logic [15:0] addr = '0, data_in = '0;
  logic ready, data_valid;
  logic [15:0] data_out;
  logic [1:0] beat;
  logic [15:0] model [0:1023];
  int vecs = 0, errs = 0;

  mem_responder #(.MEM_WORDS_LOG2(10), .LATENCY(LAT), .BURST_LEN(BL)) dut (
    .clk(clk), .rst(rst), .enable(enable), .wr(wr), .burst(burst), .addr(addr),
    .data_in(data_in), .ready(ready), .data_valid(data_valid), .data_out(data_out), .beat(beat)
  );

  always #5 clk = ~clk;

  task automatic do_write(input logic [15:0] a, input logic [15:0] d, input logic b, input string tag);
    vecs++;
    if (ready !== 1'b1) begin
      errs++;
      $display("FAIL %s not ready at issue: ready=%b expected 1", tag, ready);
    end
    enable = 1; wr = 1; burst = b; addr = a; data_in = d;
    @(posedge clk);
    #1 enable = 0;
    model[int'(a[10:1])] = d;
    for (int k = 0; k <= LAT; k++) begin
      @(negedge clk);
      vecs++;
      if ({ready, data_valid, data_out} !== {k >= LAT, 1'b0, 16'h0}) begin
        errs++;
        $display("FAIL %s write cycle %0d: ready=%b valid=%b data=%h expected ready=%b valid=0 data=0000",
                 tag, k, ready, data_valid, data_out, k >= LAT);
      end
    end
  endtask

  task automatic do_read(input logic [15:0] a, input logic b, input logic intrude, input string tag);
    int word, n, idx, eb;
    logic ev, er;
    logic [15:0] ed;
    word = int'(a[10:1]);
    n = b ? BL : 1;
    vecs++;
    if (ready !== 1'b1) begin
      errs++;
      $display("FAIL %s not ready at issue: ready=%b expected 1", tag, ready);
    end
    enable = 1; wr = 0; burst = b; addr = a; data_in = 16'($urandom);
    @(posedge clk);
    #1;
    if (intrude) begin
      wr = 1; addr = 16'h0020; data_in = 16'h5555;
    end else enable = 0;
    for (int k = 0; k <= LAT + n; k++) begin
      @(negedge clk);
      ev = k >= LAT && k < LAT + n;
      er = k >= LAT + n;
      eb = ev ? k - LAT : 0;
      idx = b ? (word / BL) * BL + (word + eb) % BL : word;
      ed = ev ? model[idx] : 16'h0;
      vecs++;
      if ({ready, data_valid, beat, data_out} !== {er, ev, 2'(eb), ed}) begin
        errs++;
        $display("FAIL %s read cycle %0d: ready=%b valid=%b beat=%0d data=%h expected ready=%b valid=%b beat=%0d data=%h",
                 tag, k, ready, data_valid, beat, data_out, er, ev, eb, ed);
      end
      if (intrude && k == LAT + n - 1) enable = 0;
    end
  endtask

  task automatic test_reset();
    rst = 1;
    #1;
    vecs++;
    if ({ready, data_valid, beat, data_out} !== {1'b1, 1'b0, 2'd0, 16'h0}) begin
      errs++;
      $display("FAIL reset: ready=%b valid=%b beat=%0d data=%h expected 1 0 0 0000", ready, data_valid, beat, data_out);
    end
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_init();
    for (int i = 0; i < 64; i++) do_write(16'(i * 2), 16'($urandom), 1'b0, "init");
  endtask

  task automatic test_write_read();
    do_write(16'h0010, 16'h1234, 1'b0, "wr_1234");
    do_read(16'h0010, 1'b0, 1'b0, "rd_1234");
  endtask

  task automatic test_burst_wrap();
    do_write(16'h0008, 16'hA0A0, 1'b0, "wrap_w0");
    do_write(16'h000A, 16'hB1B1, 1'b0, "wrap_w1");
    do_write(16'h000C, 16'hC2C2, 1'b0, "wrap_w2");
    do_write(16'h000E, 16'hD3D3, 1'b0, "wrap_w3");
    do_read(16'h000C, 1'b1, 1'b0, "burst_wrap");
  endtask

  task automatic test_busy_ignore();
    do_read(16'h0010, 1'b0, 1'b1, "busy_rd");
    do_read(16'h0020, 1'b0, 1'b0, "busy_check");
    do_read(16'h000A, 1'b1, 1'b1, "busy_burst");
    do_read(16'h0020, 1'b0, 1'b0, "busy_check2");
  endtask

  task automatic test_abort();
    enable = 1; wr = 0; burst = 1; addr = 16'h000C;
    @(posedge clk);
    #1 enable = 0;
    repeat (6) @(negedge clk);
    vecs++;
    if (data_valid !== 1'b1) begin
      errs++;
      $display("FAIL abort pre: valid=%b expected 1", data_valid);
    end
    #1 rst = 1;
    #1;
    vecs++;
    if ({ready, data_valid, beat, data_out} !== {1'b1, 1'b0, 2'd0, 16'h0}) begin
      errs++;
      $display("FAIL abort: ready=%b valid=%b beat=%0d data=%h expected 1 0 0 0000", ready, data_valid, beat, data_out);
    end
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    do_read(16'h0008, 1'b1, 1'b0, "abort_retain");
  endtask

  task automatic test_alias();
    do_write(16'hF810, 16'h7777, 1'b1, "alias_wr");
    do_read(16'h0010, 1'b0, 1'b0, "alias_rd");
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      logic [15:0] a;
      a = 16'($urandom) & 16'hF87F;
      if ($urandom_range(0, 2) == 0) do_write(a, 16'($urandom), 1'($urandom), "rand_wr");
      else do_read(a, 1'($urandom), 1'($urandom_range(0, 3) == 0), "rand_rd");
    end
  endtask

  initial begin
    test_reset();
    test_init();
    test_write_read();
    test_burst_wrap();
    test_busy_ignore();
    test_abort();
    test_alias();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, expected finish before 200000");
    $fatal(1);
  end
endmodule
